// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Computes the GF(2^8) multiplicative inverse (x^254, with 0 mapping to 0)
// followed by the FIPS-197 affine transform.
// Ports:
//   in_byte  - input byte
//   out_byte - substituted byte
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    always_comb begin
        logic [7:0] sq;
        sq  = in_byte;
        inv = 8'h01;
        // Accumulate x^2 * x^4 * ... * x^128 = x^254, the inverse of x.
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule.
// A rising edge of load_key in IDLE captures key_in as rk[0]. One round key per cycle is then
// produced into an 11-entry store through a single reused word path, and completion is
// signalled with a one-cycle chg_key_done pulse.
// Ports:
//   clk, n_rst   - clock, asynchronous active-low reset
//   load_key     - load request level; only its rising edge starts an expansion
//   key_in       - 128-bit cipher key, byte 0 in bits [127:120]
//   round_sel    - round key index for the combinational read port
//   round_key    - rk[round_sel], or 0 when round_sel > 10
//   chg_key_done - one-cycle pulse in the cycle after rk[10] is written
//   key_valid    - store holds a complete schedule
//   busy         - expansion in progress, capture through chg_key_done inclusive
module aes_key_expander #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load_key,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_sel,
    output logic [127:0] round_key,
    output logic         chg_key_done,
    output logic         key_valid,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e       state_q, state_d;
    logic         load_key_q;
    logic [127:0] rk_q [NR+1];
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;
    logic         key_valid_q;

    logic         start;
    logic [127:0] prev_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word, sub_word, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign start = load_key & ~load_key_q;

    // Key of the previous round, feeding the shared word path.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (cnt_q == 4'(i + 1)) prev_key = rk_q[i];
        end
    end

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*g +: 8]),
            .out_byte (sub_word[8*g +: 8])
        );
    end

    assign t_word   = sub_word ^ {rcon_q, 24'h0};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Read port: indices past the store read as zero.
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_sel == 4'(i)) round_key = rk_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StExpand;
            StExpand: if (cnt_q == 4'(NR)) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            load_key_q  <= 1'b0;
            rcon_q      <= 8'h01;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            load_key_q <= load_key;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rk_q[0]     <= key_in;
                        rcon_q      <= 8'h01;
                        cnt_q       <= 4'd1;
                        key_valid_q <= 1'b0;
                    end
                end
                StExpand: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (cnt_q == 4'(i)) rk_q[i] <= next_key;
                    end
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    cnt_q  <= cnt_q + 4'd1;
                end
                StDone:  key_valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign chg_key_done = (state_q == StDone);
    assign key_valid    = key_valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: stimulus pushes the expected rk1/rk10 and done cycle,
// a negedge monitor pops and checks them whenever chg_key_done is seen.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         load_key = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   round_sel = 4'd0;
    logic [127:0] round_key;
    logic         chg_key_done;
    logic         key_valid;
    logic         busy;

    aes_key_expander #(.NR(10)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_key     (load_key),
        .key_in       (key_in),
        .round_sel    (round_sel),
        .round_key    (round_key),
        .chg_key_done (chg_key_done),
        .key_valid    (key_valid),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    localparam logic [127:0] KeyA    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KeyA1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KeyA10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KeyZ    = 128'h0;
    localparam logic [127:0] KeyZ1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KeyZ10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KeyB    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KeyB1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KeyB10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [127:0] rk1;
        logic [127:0] rk10;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_count = 0;
    bit   done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: on every done pulse, pop the oldest expectation and read the store back.
    always @(negedge clk) begin
        bit   cur_done;
        exp_t e;
        cur_done = chg_key_done;
        if (cur_done) begin
            done_count++;
            check("done_one_cycle", {127'b0, done_prev}, 128'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("done_latency", 128'(cyc), 128'(e.exp_cyc));
                check("busy_at_done", {127'b0, busy}, 128'd1);
                check("valid_low_at_done", {127'b0, key_valid}, 128'd0);
                round_sel = 4'd1;
                #1 check("rk1", round_key, e.rk1);
                round_sel = 4'd10;
                #1 check("rk10", round_key, e.rk10);
                for (int s = 11; s < 16; s++) begin
                    round_sel = 4'(s);
                    #1 check("rk_out_of_range", round_key, 128'd0);
                end
                round_sel = 4'd0;
            end
        end
        done_prev = cur_done;
    end

    task automatic do_load(input logic [127:0] key, input bit push,
                           input logic [127:0] rk1, input logic [127:0] rk10);
        exp_t e;
        @(negedge clk);
        key_in   = key;
        load_key = 1'b1;
        if (push) begin
            e.rk1     = rk1;
            e.rk10    = rk10;
            e.exp_cyc = cyc + 11;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
        end
    endtask

    initial begin
        int d0;
        int n;

        // Reset state.
        #1;
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, chg_key_done}, 128'd0);
        check("rst_valid", {127'b0, key_valid}, 128'd0);
        check("rst_rk0", round_key, 128'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // FIPS-197 App. A key.
        do_load(KeyA, 1'b1, KeyA1, KeyA10);
        wait_idle("keyA");
        load_key = 1'b0;
        check("valid_after_A", {127'b0, key_valid}, 128'd1);

        // All-zero key.
        do_load(KeyZ, 1'b1, KeyZ1, KeyZ10);
        wait_idle("keyZ");
        load_key = 1'b0;

        // Level held high for 20 cycles: one expansion only.
        d0 = done_count;
        do_load(KeyB, 1'b1, KeyB1, KeyB10);
        repeat (20) @(negedge clk);
        load_key = 1'b0;
        check("hold_single_done", 128'(done_count - d0), 128'd1);

        // Toggle load_key and change key_in during EXPAND.
        d0 = done_count;
        do_load(KeyA, 1'b1, KeyA1, KeyA10);
        repeat (2) @(negedge clk);
        load_key = 1'b0;
        key_in   = KeyB;
        @(negedge clk);
        load_key = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        load_key = 1'b0;
        @(negedge clk);
        load_key = 1'b1;
        @(negedge clk);
        load_key = 1'b0;
        wait_idle("toggle");
        repeat (3) @(negedge clk);
        check("toggle_single_done", 128'(done_count - d0), 128'd1);

        // Reset in the middle of an expansion.
        d0 = done_count;
        do_load(KeyZ, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        n_rst    = 1'b0;
        load_key = 1'b0;
        #1;
        check("midrst_busy", {127'b0, busy}, 128'd0);
        check("midrst_done", {127'b0, chg_key_done}, 128'd0);
        check("midrst_valid", {127'b0, key_valid}, 128'd0);
        check("midrst_rk0", round_key, 128'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_valid_stays_low", {127'b0, key_valid}, 128'd0);
        check("midrst_no_done", 128'(done_count - d0), 128'd0);
        do_load(KeyB, 1'b1, KeyB1, KeyB10);
        wait_idle("after_rst");
        load_key = 1'b0;
        check("valid_after_rst_load", {127'b0, key_valid}, 128'd1);

        // Key A then key B: key_valid drops at the B capture, rises 11 cycles later.
        @(negedge clk);
        do_load(KeyA, 1'b1, KeyA1, KeyA10);
        wait_idle("AB_a");
        load_key = 1'b0;
        check("valid_before_B", {127'b0, key_valid}, 128'd1);
        @(negedge clk);
        do_load(KeyB, 1'b1, KeyB1, KeyB10);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("valid_B_cycle%0d", k), {127'b0, key_valid}, (k == 12) ? 128'd1 : 128'd0);
        end
        load_key = 1'b0;

        // Drain the scoreboard.
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_done: got %0d outstanding, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
